// File: rtl/ddr3_rw_pkg.sv
// Shared types for the DDR3 read/write arbiter: FSM states, grant sides, data width.
package ddr3_rw_pkg;

  localparam int unsigned DATA_W = 128;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdData
  } state_e;

  typedef enum logic {
    GrantWrite,
    GrantRead
  } grant_e;

endpackage

// File: rtl/ddr3_rw_arbiter_if.sv
// FIFO-side and AXI-style DDR3 user-port signals seen by the read/write arbiter.
interface ddr3_rw_arbiter_if #(
  parameter int unsigned ADDR_W = 28
);
  import ddr3_rw_pkg::*;

  logic              ddr_init_done;
  logic [10:0]       wfifo_rcount;
  logic [DATA_W-1:0] wfifo_dout;
  logic              wfifo_rden;
  logic [10:0]       rfifo_wcount;
  logic [DATA_W-1:0] rfifo_din;
  logic              rfifo_wren;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wlast;
  logic              wready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rlast;
  logic              rd_err;

  // Arbiter side.
  modport master (
    input  ddr_init_done, wfifo_rcount, wfifo_dout, rfifo_wcount,
    input  awready, wready, arready, rdata, rvalid, rlast,
    output wfifo_rden, rfifo_din, rfifo_wren,
    output awaddr, awlen, awvalid, wdata, wvalid, wlast,
    output araddr, arlen, arvalid, rd_err
  );

  // FIFO pair plus DDR3 controller side.
  modport slave (
    output ddr_init_done, wfifo_rcount, wfifo_dout, rfifo_wcount,
    output awready, wready, arready, rdata, rvalid, rlast,
    input  wfifo_rden, rfifo_din, rfifo_wren,
    input  awaddr, awlen, awvalid, wdata, wvalid, wlast,
    input  araddr, arlen, arvalid, rd_err
  );

endinterface

// File: rtl/ddr3_addr_gen.sv
// Burst address generator: starts at BASE, steps by STEP on each advance pulse and
// wraps back to BASE once the next address would reach BASE+LIMIT.
module ddr3_addr_gen #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned BASE   = 0,
  parameter int unsigned STEP   = 128,
  parameter int unsigned LIMIT  = 786432
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr
);

  // One extra bit so the sum cannot overflow before the wrap comparison.
  localparam int unsigned EXT_W = ADDR_W + 1;
  localparam logic [EXT_W-1:0] STEP_X = EXT_W'(STEP);
  localparam logic [EXT_W-1:0] END_X  = EXT_W'(64'(BASE) + 64'(LIMIT));

  logic [ADDR_W-1:0] r_addr;
  logic [EXT_W-1:0]  w_next;

  assign w_next = {1'b0, r_addr} + STEP_X;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= ADDR_W'(BASE);
    end else if (i_advance) begin
      r_addr <= (w_next >= END_X) ? ADDR_W'(BASE) : w_next[ADDR_W-1:0];
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Round-robin mover between the user write/read FIFOs and the DDR3 user port,
// issuing fixed-length bursts with independent wrapping write and read addresses.
module ddr3_rw_arbiter
  import ddr3_rw_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned ADDR_STEP   = 128,
  parameter int unsigned WR_BASE     = 0,
  parameter int unsigned RD_BASE     = 0,
  parameter int unsigned ADDR_LIMIT  = 786432,
  parameter int unsigned RFIFO_DEPTH = 1024
) (
  input logic               clk_100,
  input logic               rst_n,
  ddr3_rw_arbiter_if.master bus
);

  localparam int unsigned      CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [10:0]      WR_THRESH = 11'(BURST_LEN);
  localparam logic [10:0]      RD_THRESH = 11'(RFIFO_DEPTH - BURST_LEN);

  state_e           r_state;
  grant_e           r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_awvalid;
  logic             r_wvalid;
  logic             r_wlast;
  logic             r_arvalid;
  logic             r_rd_err;

  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_cnt_last;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_wr_beat;
  logic              w_rd_beat;
  logic              w_wr_adv;
  logic              w_rd_adv;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_wr_req   = bus.ddr_init_done && (bus.wfifo_rcount >= WR_THRESH);
  assign w_rd_req   = bus.ddr_init_done && (bus.rfifo_wcount <= RD_THRESH);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_wr_beat  = (r_state == StWrData) && r_wvalid && bus.wready;
  assign w_rd_beat  = (r_state == StRdData) && bus.rvalid;
  // A read burst closes on rlast or on the expected final beat, whichever comes first.
  assign w_rd_adv   = w_rd_beat && (bus.rlast || w_cnt_last);
  assign w_wr_adv   = w_wr_beat && r_wlast;

  ddr3_addr_gen #(
    .ADDR_W (ADDR_W),
    .BASE   (WR_BASE),
    .STEP   (ADDR_STEP),
    .LIMIT  (ADDR_LIMIT)
  ) u_wr_addr_gen (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .i_advance (w_wr_adv),
    .o_addr    (w_wr_addr)
  );

  ddr3_addr_gen #(
    .ADDR_W (ADDR_W),
    .BASE   (RD_BASE),
    .STEP   (ADDR_STEP),
    .LIMIT  (ADDR_LIMIT)
  ) u_rd_addr_gen (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .i_advance (w_rd_adv),
    .o_addr    (w_rd_addr)
  );

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= GrantRead;
      r_cnt        <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rd_err     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // With both sides requesting, the side not served last wins.
          if (w_wr_req && (!w_rd_req || (r_last_grant == GrantRead))) begin
            r_state      <= StWrAddr;
            r_awvalid    <= 1'b1;
            r_last_grant <= GrantWrite;
          end else if (w_rd_req) begin
            r_state      <= StRdAddr;
            r_arvalid    <= 1'b1;
            r_last_grant <= GrantRead;
          end
        end
        StWrAddr: begin
          if (bus.awready) begin
            r_state   <= StWrData;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (CNT_LAST == '0);
          end
        end
        StWrData: begin
          if (bus.wready) begin
            if (r_wlast) begin
              r_state  <= StIdle;
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_cnt    <= '0;
            end else begin
              r_cnt   <= w_cnt_next;
              r_wlast <= (w_cnt_next == CNT_LAST);
            end
          end
        end
        StRdAddr: begin
          if (bus.arready) begin
            r_state   <= StRdData;
            r_arvalid <= 1'b0;
          end
        end
        StRdData: begin
          if (bus.rvalid) begin
            if (bus.rlast || w_cnt_last) begin
              r_state <= StIdle;
              r_cnt   <= '0;
              if (bus.rlast != w_cnt_last) begin
                r_rd_err <= 1'b1;
              end
            end else begin
              r_cnt <= w_cnt_next;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.awaddr     = w_wr_addr;
  assign bus.awlen      = 4'(BURST_LEN - 1);
  assign bus.awvalid    = r_awvalid;
  assign bus.wdata      = bus.wfifo_dout;
  assign bus.wvalid     = r_wvalid;
  assign bus.wlast      = r_wlast;
  assign bus.wfifo_rden = r_wvalid && bus.wready;
  assign bus.araddr     = w_rd_addr;
  assign bus.arlen      = 4'(BURST_LEN - 1);
  assign bus.arvalid    = r_arvalid;
  assign bus.rfifo_wren = w_rd_beat;
  assign bus.rfifo_din  = bus.rdata;
  assign bus.rd_err     = r_rd_err;

endmodule
